// File: rtl/noc_inj_arb_pkg.sv
// Shared types and helpers for the NoC injection arbiter.
package noc_inj_arb_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    function automatic int next_rr(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational circular priority search: first set req bit at or after ptr.
module rr_priority_picker #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant,
    output logic          any_grant
);

    int            idx;
    logic [PW-1:0] idx_w;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx   = (int'(ptr) + k) % N;
            idx_w = PW'(idx);
            if (req[idx_w]) begin
                grant     = idx_w;
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_injection_arbiter.sv
// Packet-atomic round-robin arbiter feeding one credit-flow-controlled router injection port.
// Optional consistency checker (err_sticky) enabled by NOC_INJ_ARB_CHECK_EN.
//
//   state  | meaning
//   IDLE   | no packet in flight; grant goes to the next valid source from rr_ptr
//   LOCKED | owner is mid-packet; only owner may send until its tail is accepted
module noc_injection_arbiter
    import noc_inj_arb_pkg::*;
#(
    parameter int NUM_INPUTS        = 4,
    parameter int FLIT_WIDTH        = 128,
    parameter int DEST_WIDTH        = 6,
    parameter int FLIT_BUFFER_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_INPUTS-1:0]            in_valid,
    output logic [NUM_INPUTS-1:0]            in_ready,
    input  logic [NUM_INPUTS*FLIT_WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS*DEST_WIDTH-1:0] in_dest,
    input  logic [NUM_INPUTS-1:0]            in_is_tail,
    output logic [FLIT_WIDTH-1:0]            data_out,
    output logic [DEST_WIDTH-1:0]            dest_out,
    output logic                             is_tail_out,
    output logic                             send_out,
    input  logic                             credit_in
`ifdef NOC_INJ_ARB_CHECK_EN
    ,
    output logic                             err_sticky
`endif
);

    localparam int PW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(FLIT_BUFFER_DEPTH);

    arb_state_t              state;
    logic [PW-1:0]           owner;
    logic [PW-1:0]           rr_ptr;
    logic [PW-1:0]           grant;
    logic [PW-1:0]           acc_idx;
    logic                    any_grant;
    logic [CW-1:0]           credits;
    logic                    accept;
    logic                    sel_tail;
    logic [FLIT_WIDTH-1:0]   sel_data;
    logic [DEST_WIDTH-1:0]   sel_dest;
`ifdef NOC_INJ_ARB_CHECK_EN
    logic [DEST_WIDTH-1:0]   head_dest;
`endif

    rr_priority_picker #(.N(NUM_INPUTS)) u_picker (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .any_grant (any_grant)
    );

    // in_ready is gated by rst_n so nothing is handshaken while the router is held in reset.
    always_comb begin
        acc_idx  = (state == LOCKED) ? owner : grant;
        accept   = 1'b0;
        if (rst_n && credits != '0) begin
            accept = (state == LOCKED) ? in_valid[owner] : any_grant;
        end
        in_ready = '0;
        if (accept) begin
            in_ready[acc_idx] = 1'b1;
        end
        sel_data = '0;
        sel_dest = '0;
        sel_tail = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (acc_idx == PW'(i)) begin
                sel_data = in_data[i*FLIT_WIDTH +: FLIT_WIDTH];
                sel_dest = in_dest[i*DEST_WIDTH +: DEST_WIDTH];
                sel_tail = in_is_tail[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            credits     <= CREDIT_MAX;
            send_out    <= 1'b0;
            data_out    <= '0;
            dest_out    <= '0;
            is_tail_out <= 1'b0;
`ifdef NOC_INJ_ARB_CHECK_EN
            head_dest   <= '0;
            err_sticky  <= 1'b0;
`endif
        end else begin
            send_out <= accept;
            if (accept) begin
                data_out    <= sel_data;
                dest_out    <= sel_dest;
                is_tail_out <= sel_tail;
            end

            // Simultaneous accept and return cancel out; returns at full are dropped.
            if (accept && !credit_in) begin
                credits <= credits - CW'(1);
            end else if (!accept && credit_in && credits != CREDIT_MAX) begin
                credits <= credits + CW'(1);
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        if (sel_tail) begin
                            rr_ptr <= PW'(next_rr(int'(grant), NUM_INPUTS));
                        end else begin
                            state <= LOCKED;
                            owner <= grant;
`ifdef NOC_INJ_ARB_CHECK_EN
                            head_dest <= sel_dest;
`endif
                        end
                    end
                end
                LOCKED: begin
                    if (accept && sel_tail) begin
                        state  <= IDLE;
                        rr_ptr <= PW'(next_rr(int'(owner), NUM_INPUTS));
                    end
                end
            endcase

`ifdef NOC_INJ_ARB_CHECK_EN
            if (credit_in && credits == CREDIT_MAX) begin
                err_sticky <= 1'b1;
            end
            if (state == LOCKED && accept && sel_dest != head_dest) begin
                err_sticky <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_noc_injection_arbiter.sv
// Self-checking bench for noc_injection_arbiter against a behavioural packet/credit model.
module tb_noc_injection_arbiter;

    localparam int N  = 4;
    localparam int FW = 128;
    localparam int DW = 6;
    localparam int D  = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*FW-1:0] in_data;
    logic [N*DW-1:0] in_dest;
    logic [N-1:0]    in_is_tail;
    logic [FW-1:0]   data_out;
    logic [DW-1:0]   dest_out;
    logic            is_tail_out;
    logic            send_out;
    logic            credit_in;
`ifdef NOC_INJ_ARB_CHECK_EN
    logic            err_sticky;
`endif

    noc_injection_arbiter #(
        .NUM_INPUTS(N), .FLIT_WIDTH(FW), .DEST_WIDTH(DW), .FLIT_BUFFER_DEPTH(D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_dest     (in_dest),
        .in_is_tail  (in_is_tail),
        .data_out    (data_out),
        .dest_out    (dest_out),
        .is_tail_out (is_tail_out),
        .send_out    (send_out),
        .credit_in   (credit_in)
`ifdef NOC_INJ_ARB_CHECK_EN
        ,
        .err_sticky  (err_sticky)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model: packet lock, circular pointer, credit count, last registered flit.
    int            m_cred;
    int            m_ptr;
    int            m_owner;
    bit            m_locked;
    logic          m_send;
    logic          m_tail;
    logic [DW-1:0] m_dest;
    logic [FW-1:0] m_data;
    int            last_dut_pick;

    function automatic logic [FW-1:0] rnd_flit();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        m_cred = D; m_ptr = 0; m_owner = 0; m_locked = 0;
        m_send = 0; m_tail = 0; m_dest = '0; m_data = '0;
    endtask

    function automatic int model_pick();
        if (!rst_n || m_cred == 0) return -1;
        if (m_locked) return in_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_update(input int p);
        bit acc;
        acc = (p >= 0);
        m_send = acc;
        if (acc) begin
            m_data = in_data[p*FW +: FW];
            m_dest = in_dest[p*DW +: DW];
            m_tail = in_is_tail[p];
            if (in_is_tail[p]) begin
                m_locked = 0;
                m_ptr = (p + 1) % N;
            end else begin
                m_locked = 1;
                m_owner = p;
            end
        end
        if (acc && !credit_in) m_cred--;
        else if (!acc && credit_in && m_cred < D) m_cred++;
    endtask

    task automatic set_src(input int i, input bit v, input bit t, input logic [DW-1:0] d);
        in_valid[i] = v;
        in_is_tail[i] = t;
        in_dest[i*DW +: DW] = d;
        in_data[i*FW +: FW] = rnd_flit();
    endtask

    // One clock: check in_ready before the edge, then the registered outputs after it.
    task automatic cycle();
        int p;
        logic [N-1:0] exp_rdy;
        #1;
        p = model_pick();
        exp_rdy = '0;
        if (p >= 0) exp_rdy[p] = 1'b1;
        last_dut_pick = -1;
        for (int i = 0; i < N; i++) if (in_ready[i] === 1'b1) last_dut_pick = i;
        total++;
        if (in_ready !== exp_rdy) begin
            bad++;
            $display("FAIL in_ready t=%0t got=%b want=%b", $time, in_ready, exp_rdy);
        end
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update(p);
        #1;
        total++;
        if ({send_out, is_tail_out, dest_out, data_out} !== {m_send, m_tail, m_dest, m_data}) begin
            bad++;
            $display("FAIL outputs t=%0t got send=%b tail=%b dest=%h data=%h want send=%b tail=%b dest=%h data=%h",
                     $time, send_out, is_tail_out, dest_out, data_out, m_send, m_tail, m_dest, m_data);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = '0;
        in_is_tail = '0;
        credit_in = 1'b0;
    endtask

    task automatic restore_credits();
        in_valid = '0;
        for (int k = 0; k < 12 && m_cred < D; k++) begin
            credit_in = 1'b1;
            cycle();
        end
        credit_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = '1;
        in_is_tail = '1;
        cycle();
        total++;
        if (last_dut_pick != -1) begin
            bad++;
            $display("FAIL reset_ready got=%0d want=-1", last_dut_pick);
        end
        cycle();
        rst_n = 1'b1;
        idle_inputs();
        cycle();
    endtask

    task automatic test_round_robin();
        int exp_order[5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) set_src(i, 1, 1, DW'(i + 8));
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < N; i++) in_data[i*FW +: FW] = rnd_flit();
            credit_in = m_send;
            cycle();
            total++;
            if (last_dut_pick != exp_order[k]) begin
                bad++;
                $display("FAIL rr_order step=%0d got=%0d want=%0d", k, last_dut_pick, exp_order[k]);
            end
        end
        idle_inputs();
        restore_credits();
    endtask

    task automatic test_locked_packet();
        set_src(0, 1, 1, 6'h10);
        set_src(2, 1, 0, 6'h22);
        for (int k = 0; k < 3; k++) begin
            set_src(1, 1, k == 2, 6'h11);
            credit_in = m_send;
            cycle();
            total++;
            if (last_dut_pick != 1) begin
                bad++;
                $display("FAIL lock_owner flit=%0d got=%0d want=1", k, last_dut_pick);
            end
        end
        in_valid[1] = 1'b0;
        credit_in = m_send;
        cycle();
        total++;
        if (last_dut_pick != 2) begin
            bad++;
            $display("FAIL lock_next_head got=%0d want=2", last_dut_pick);
        end
        set_src(2, 1, 1, 6'h22);
        credit_in = m_send;
        cycle();
        total++;
        if (last_dut_pick != 2) begin
            bad++;
            $display("FAIL lock_tail2 got=%0d want=2", last_dut_pick);
        end
        idle_inputs();
        restore_credits();
    endtask

    task automatic test_credit_exhaust();
        int acc_cnt;
        acc_cnt = 0;
        idle_inputs();
        set_src(0, 1, 1, 6'h05);
        for (int k = 0; k < 6; k++) begin
            in_data[0 +: FW] = rnd_flit();
            cycle();
            if (last_dut_pick == 0) acc_cnt++;
        end
        total++;
        if (acc_cnt != D) begin
            bad++;
            $display("FAIL exhaust_count got=%0d want=%0d", acc_cnt, D);
        end
        credit_in = 1'b1;
        cycle();
        total++;
        if (last_dut_pick != -1) begin
            bad++;
            $display("FAIL exhaust_credit_cycle got=%0d want=-1", last_dut_pick);
        end
        credit_in = 1'b0;
        in_data[0 +: FW] = rnd_flit();
        cycle();
        total++;
        if (last_dut_pick != 0) begin
            bad++;
            $display("FAIL exhaust_resume got=%0d want=0", last_dut_pick);
        end
        cycle();
        idle_inputs();
        restore_credits();
    endtask

    task automatic test_same_cycle();
        idle_inputs();
        set_src(0, 1, 1, 6'h07);
        for (int k = 0; k < 3; k++) begin
            in_data[0 +: FW] = rnd_flit();
            cycle();
        end
        credit_in = 1'b1;
        in_data[0 +: FW] = rnd_flit();
        cycle();
        total++;
        if (last_dut_pick != 0) begin
            bad++;
            $display("FAIL same_cycle_accept got=%0d want=0", last_dut_pick);
        end
        credit_in = 1'b0;
        in_data[0 +: FW] = rnd_flit();
        cycle();
        total++;
        if (last_dut_pick != 0) begin
            bad++;
            $display("FAIL same_cycle_b2b got=%0d want=0", last_dut_pick);
        end
        cycle();
        total++;
        if (last_dut_pick != -1) begin
            bad++;
            $display("FAIL same_cycle_empty got=%0d want=-1", last_dut_pick);
        end
        idle_inputs();
        restore_credits();
    endtask

    task automatic test_reset_mid();
        int acc_cnt;
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            set_src(1, 1, 0, 6'h31);
            cycle();
        end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        in_valid[1] = 1'b0;
        acc_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            set_src(3, 1, 0, 6'h33);
            cycle();
            if (last_dut_pick == 3) acc_cnt++;
            if (k == 0) begin
                total++;
                if (last_dut_pick != 3) begin
                    bad++;
                    $display("FAIL reset_mid_head got=%0d want=3", last_dut_pick);
                end
            end
        end
        total++;
        if (acc_cnt != D) begin
            bad++;
            $display("FAIL reset_mid_credits got=%0d want=%0d", acc_cnt, D);
        end
        set_src(3, 1, 1, 6'h33);
        credit_in = 1'b1;
        cycle();
        credit_in = 1'b0;
        cycle();
        idle_inputs();
        restore_credits();
    endtask

    task automatic test_random();
        logic [DW-1:0] sd[N];
        for (int i = 0; i < N; i++) sd[i] = DW'($urandom);
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < N; i++) set_src(i, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, sd[i]);
            credit_in = (m_cred < D) ? $urandom_range(0, 1) : 1'b0;
            cycle();
        end
        idle_inputs();
        restore_credits();
    endtask

`ifdef NOC_INJ_ARB_CHECK_EN
    task automatic test_err();
        idle_inputs();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        total++;
        if (err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL err_reset got=%b want=0", err_sticky);
        end
        credit_in = 1'b1;
        cycle();
        credit_in = 1'b0;
        total++;
        if (err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL err_overflow got=%b want=1", err_sticky);
        end
        set_src(0, 1, 1, 6'h01);
        for (int k = 0; k < 3; k++) begin
            credit_in = m_send;
            cycle();
        end
        idle_inputs();
        restore_credits();
        total++;
        if (err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL err_hold got=%b want=1", err_sticky);
        end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        set_src(2, 1, 0, 6'h05);
        cycle();
        total++;
        if (err_sticky !== 1'b0) begin
            bad++;
            $display("FAIL err_head_ok got=%b want=0", err_sticky);
        end
        set_src(2, 1, 1, 6'h09);
        cycle();
        total++;
        if (err_sticky !== 1'b1) begin
            bad++;
            $display("FAIL err_dest got=%b want=1", err_sticky);
        end
        idle_inputs();
        restore_credits();
    endtask
`endif

    initial begin
        in_valid = '0;
        in_is_tail = '0;
        in_data = '0;
        in_dest = '0;
        credit_in = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_locked_packet();
        test_credit_exhaust();
        test_same_cycle();
        test_reset_mid();
        test_random();
`ifdef NOC_INJ_ARB_CHECK_EN
        test_err();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_injection_arbiter.md
Name: noc_injection_arbiter

Overview:
- Shares one router injection port (flit interface: data/dest/is_tail/send with credit return) among NUM_INPUTS local flit sources, for example several serializer shims on one NoC endpoint.
- Arbitration is packet-atomic round-robin. Once a source wins, only that source may send until its tail flit is accepted.
- Holds a credit counter that mirrors the router's input flit buffer, so no flit is ever sent without a free slot.
- Sits between the shim-side flit outputs and the router's data_in/dest_in/is_tail_in/send_in/credit_out ports.

Parameters:
- NUM_INPUTS, 4, number of requesting sources (2..16).
- FLIT_WIDTH, 128, flit payload width.
- DEST_WIDTH, 6, destination field width ({tid, tdest}).
- FLIT_BUFFER_DEPTH, 4, router input buffer depth; this is the initial and maximum credit count.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1 [NUM_INPUTS]  source i has a flit.
- in_ready  out  1 [NUM_INPUTS]  flit of source i accepted this cycle.
- in_data  in  FLIT_WIDTH [NUM_INPUTS]  flit payload.
- in_dest  in  DEST_WIDTH [NUM_INPUTS]  destination; only meaningful on the head flit.
- in_is_tail  in  1 [NUM_INPUTS]  last flit of the packet.
- data_out  out  FLIT_WIDTH  to router data_in.
- dest_out  out  DEST_WIDTH  to router dest_in.
- is_tail_out  out  1  to router is_tail_in.
- send_out  out  1  one-cycle flit-valid strobe to the router.
- credit_in  in  1  one-cycle pulse from the router: one buffer slot freed.

Behaviour:
- Reset (rst_n=0 at a clk edge), synchronous, active-low:
  - state=IDLE, owner=0, rr_ptr=0, credits=FLIT_BUFFER_DEPTH.
  - send_out=0, data_out/dest_out/is_tail_out=0.
  - in_ready is forced to 0 while rst_n=0.
- Reset mid-packet: the partial packet is abandoned and credits are restored to full. The router must be reset in the same cycle; this is a system requirement.
- Credits:
  - Counter width is $clog2(FLIT_BUFFER_DEPTH+1).
  - Accept only (no credit_in) → −1. credit_in only → +1. Both in the same cycle → unchanged.
  - credit_in when credits==FLIT_BUFFER_DEPTH is ignored; the counter saturates.
- State IDLE:
  - If credits>0 and any in_valid, grant the first valid index at or after rr_ptr (circular search).
  - in_ready[grant]=1 in the same cycle. in_ready depends combinationally on in_valid and credits; in_valid must never depend on in_ready.
  - If the accepted flit has is_tail=1 (single-flit packet): stay IDLE, rr_ptr=grant+1 mod NUM_INPUTS.
  - Otherwise: go to LOCKED with owner=grant.
- State LOCKED:
  - in_ready[owner]=in_valid[owner] && credits>0. All other in_ready=0.
  - Accepting a tail flit → IDLE, rr_ptr=owner+1 mod NUM_INPUTS.
  - The owner may drop in_valid mid-packet; the lock is held indefinitely.
- Output stage:
  - On acceptance, the next edge registers the flit into data_out/dest_out/is_tail_out and sets send_out=1.
  - With no acceptance, send_out=0 next cycle. Data outputs hold their last value.
  - Latency is exactly 1 cycle from acceptance to send_out.
  - Throughput is 1 flit/cycle while credits>0.
- Credits=0: no in_ready asserted in any state. Acceptance resumes the cycle after credit_in raises the count.
- Lone valid source: it wins every packet regardless of rr_ptr.
- Flits are never reordered or dropped. A send_out is issued only for an accepted flit.

Optional Feature:
- Macro: NOC_INJ_ARB_CHECK_EN.
- Defined:
  - Adds output port err_sticky (1 bit, reset 0).
  - err_sticky sets and holds until reset when either:
    - credit_in arrives at full credits (overflow);
    - in_dest[owner] of an accepted LOCKED-state flit differs from the registered head dest.
  - Adds a DEST_WIDTH head-dest register.
- Undefined: no port, no extra register, and the saturating behaviour is unchanged.

Decomposition:
- Package noc_inj_arb_pkg:
  - typedef enum logic {IDLE, LOCKED} arb_state_t;
  - function next_rr(ptr, n) returning ptr+1 wrapping to 0.
- Sub-module rr_priority_picker (parameter N): inputs req[N] and ptr; outputs grant index and any_grant; purely combinational circular search.
- Top-level noc_injection_arbiter holds the FSM, credit counter and output registers.

Test Plan:
- Single-flit packets, all four sources valid, credits=4, credit_in pulsed each send → accepted in order 0,1,2,3,0; one send_out per cycle; credits stay ≥1.
- Source 1 sends a 3-flit packet (tail on flit 3) while source 2 is valid → source 2 in_ready=0 until flit 3 is accepted; source 2's head is accepted the next cycle; rr_ptr=2.
- No credit_in, source 0 sends 6 single-flit packets → exactly 4 accepted, then in_ready=0. One credit_in pulse → 5th flit accepted the next cycle and send_out 1 cycle later.
- Accept and credit_in in the same cycle at credits=1 → credits stays 1, and the next flit is accepted back-to-back.
- rst_n=0 for one cycle mid-packet (LOCKED, credits=1) → next cycle: send_out=0, credits=4, state IDLE, and a new head from source 3 is accepted.
- With NOC_INJ_ARB_CHECK_EN defined: a credit_in pulse at credits=4 → err_sticky=1 the next cycle and held through later traffic.
